// File: rtl/sub_pkg.sv
// rtl/sub_pkg.sv - shared state type for the sequential subtractor
package sub_pkg;

    // Controller phases: waiting for operands, computing slices, holding a result
    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

endpackage : sub_pkg

// File: rtl/digit_sub.sv
// rtl/digit_sub.sv - combinational DIGIT-bit ripple-borrow subtract slice
module digit_sub #(
    parameter int DIGIT = 4
) (
    input  logic [DIGIT-1:0] a,
    input  logic [DIGIT-1:0] b,
    input  logic             bw_in,
    output logic [DIGIT-1:0] d,
    output logic             bw_out
);

    logic [DIGIT:0] w_sum;

    // Subtraction as a + ~b + carry, where a pending borrow removes the +1 carry
    always_comb begin
        w_sum  = {1'b0, a} + {1'b0, ~b} + {{DIGIT{1'b0}}, ~bw_in};
        d      = w_sum[DIGIT-1:0];
        bw_out = ~w_sum[DIGIT];
    end

endmodule : digit_sub

// File: rtl/seq_subtractor.sv
// rtl/seq_subtractor.sv - multi-cycle subtractor, one DIGIT-bit slice per clock
module seq_subtractor
    import sub_pkg::*;
#(
    parameter int WIDTH = 16,
    parameter int DIGIT = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             b_in,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] diff,
    output logic             b_out,
    output logic             ovf,
    output logic             zero
);

    localparam int N  = WIDTH / DIGIT;
    localparam int CW = (N > 1) ? $clog2(N) : 1;
    localparam logic [CW-1:0] LAST = CW'(N - 1);

    state_t           r_state;
    state_t           w_next;
    logic [WIDTH-1:0] r_a_sh;
    logic [WIDTH-1:0] r_b_sh;
    logic [WIDTH-1:0] r_diff;
    logic             r_borrow;
    logic [CW-1:0]    r_cnt;
    logic             r_a_msb;
    logic             r_b_msb;
    logic             r_bout;
    logic             r_ovf;
    logic             r_zero;

    logic             w_accept;
    logic             w_run;
    logic             w_last;
    logic [DIGIT-1:0] w_d;
    logic             w_bw;
    logic [WIDTH-1:0] w_diff_next;

    assign w_accept    = (r_state == IDLE) && in_valid;
    assign w_run       = (r_state == RUN);
    assign w_last      = w_run && (r_cnt == LAST);
    // New slice enters at the MSB end so the LSB slice lands at bit 0 after N shifts
    assign w_diff_next = (r_diff >> DIGIT) | (WIDTH'(w_d) << (WIDTH - DIGIT));

    digit_sub #(
        .DIGIT (DIGIT)
    ) u_slice (
        .a      (r_a_sh[DIGIT-1:0]),
        .b      (r_b_sh[DIGIT-1:0]),
        .bw_in  (r_borrow),
        .d      (w_d),
        .bw_out (w_bw)
    );

    // State register
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    // Next-state: accept in IDLE, leave RUN after the last slice, release on out_ready
    always_comb begin
        w_next = r_state;
        case (r_state)
            IDLE:    if (in_valid)  w_next = RUN;
            RUN:     if (w_last)    w_next = DONE;
            DONE:    if (out_ready) w_next = IDLE;
            default:                w_next = IDLE;
        endcase
    end

    // Operand capture, slice shifting, borrow chain and final flag registration
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_a_sh   <= '0;
            r_b_sh   <= '0;
            r_diff   <= '0;
            r_borrow <= 1'b0;
            r_cnt    <= '0;
            r_a_msb  <= 1'b0;
            r_b_msb  <= 1'b0;
            r_bout   <= 1'b0;
            r_ovf    <= 1'b0;
            r_zero   <= 1'b0;
        end else if (w_accept) begin
            r_a_sh   <= a;
            r_b_sh   <= b;
            r_borrow <= b_in;
            r_cnt    <= '0;
            r_a_msb  <= a[WIDTH-1];
            r_b_msb  <= b[WIDTH-1];
        end else if (w_run) begin
            r_a_sh   <= r_a_sh >> DIGIT;
            r_b_sh   <= r_b_sh >> DIGIT;
            r_diff   <= w_diff_next;
            r_borrow <= w_bw;
            r_cnt    <= r_cnt + CW'(1);
            if (w_last) begin
                r_bout <= w_bw;
                r_ovf  <= (r_a_msb != r_b_msb) && (w_d[DIGIT-1] != r_a_msb);
                r_zero <= (w_diff_next == '0);
            end
        end
    end

    assign in_ready  = (r_state == IDLE);
    assign out_valid = (r_state == DONE);
    assign diff      = r_diff;
    assign b_out     = r_bout;
    assign ovf       = r_ovf;
    assign zero      = r_zero;

endmodule : seq_subtractor

// File: tb/tb_seq_subtractor.sv
// tb/tb_seq_subtractor.sv - directed scoreboard bench for seq_subtractor
module tb_seq_subtractor;

    typedef struct packed {
        logic [15:0] d;
        logic        bo;
        logic        ov;
        logic        z;
    } exp_t;

    logic        clk = 1'b0;
    logic        rst;
    logic        in_valid;
    logic        in_ready;
    logic [15:0] a;
    logic [15:0] b;
    logic        b_in;
    logic        out_valid;
    logic        out_ready;
    logic [15:0] diff;
    logic        b_out;
    logic        ovf;
    logic        zero;

    int   n_asserts = 0;
    int   n_fail    = 0;
    exp_t q[$];

    always #5 clk = ~clk;

    seq_subtractor #(.WIDTH(16), .DIGIT(4)) dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .a         (a),
        .b         (b),
        .b_in      (b_in),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .diff      (diff),
        .b_out     (b_out),
        .ovf       (ovf),
        .zero      (zero)
    );

    function automatic exp_t model(input logic [15:0] ma, input logic [15:0] mb, input logic mbin);
        exp_t        e;
        logic [16:0] t;
        t    = {1'b0, ma} - {1'b0, mb} - {16'd0, mbin};
        e.d  = t[15:0];
        e.bo = t[16];
        e.ov = (ma[15] != mb[15]) && (t[15] != ma[15]);
        e.z  = (t[15:0] == 16'd0);
        return e;
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_asserts++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic start_op(input logic [15:0] va, input logic [15:0] vb, input logic vbin);
        int n = 0;
        while (!in_ready && n < 20) begin
            tick();
            n++;
        end
        chk("in_ready_before_accept", {31'd0, in_ready}, 32'd1);
        in_valid = 1'b1;
        a        = va;
        b        = vb;
        b_in     = vbin;
        q.push_back(model(va, vb, vbin));
        tick();
        in_valid = 1'b0;
    endtask

    task automatic wait_valid();
        int n = 0;
        while (!out_valid && n < 30) begin
            tick();
            n++;
        end
        chk("accept_to_valid_latency", n, 32'd4);
    endtask

    task automatic check_result();
        exp_t e;
        if (q.size() == 0) begin
            chk("scoreboard_nonempty", 32'd0, 32'd1);
        end else begin
            e = q.pop_front();
            chk("diff",  {16'd0, diff},  {16'd0, e.d});
            chk("b_out", {31'd0, b_out}, {31'd0, e.bo});
            chk("ovf",   {31'd0, ovf},   {31'd0, e.ov});
            chk("zero",  {31'd0, zero},  {31'd0, e.z});
        end
    endtask

    task automatic consume();
        out_ready = 1'b1;
        tick();
        out_ready = 1'b0;
        chk("out_valid_after_consume", {31'd0, out_valid}, 32'd0);
        chk("in_ready_after_consume",  {31'd0, in_ready},  32'd1);
    endtask

    task automatic run_op(input logic [15:0] va, input logic [15:0] vb, input logic vbin);
        start_op(va, vb, vbin);
        wait_valid();
        check_result();
        consume();
    endtask

    initial begin
        exp_t held;

        rst       = 1'b1;
        in_valid  = 1'b0;
        a         = '0;
        b         = '0;
        b_in      = 1'b0;
        out_ready = 1'b0;
        tick();
        tick();
        chk("reset_in_ready",  {31'd0, in_ready},  32'd1);
        chk("reset_out_valid", {31'd0, out_valid}, 32'd0);
        chk("reset_diff",      {16'd0, diff},      32'd0);
        chk("reset_b_out",     {31'd0, b_out},     32'd0);
        chk("reset_ovf",       {31'd0, ovf},       32'd0);
        chk("reset_zero",      {31'd0, zero},      32'd0);
        rst = 1'b0;
        tick();

        run_op(16'h1234, 16'h0034, 1'b0);
        run_op(16'h0000, 16'h0001, 1'b0);
        run_op(16'h8000, 16'h0001, 1'b0);
        run_op(16'h5A5A, 16'h5A5A, 1'b0);
        run_op(16'h1000, 16'h0001, 1'b0);

        // Back-pressure: result must hold while inputs churn
        start_op(16'hBEEF, 16'h1234, 1'b0);
        wait_valid();
        held = q[0];
        for (int i = 0; i < 6; i++) begin
            in_valid = 1'b1;
            a        = 16'($urandom);
            b        = 16'($urandom);
            b_in     = 1'($urandom);
            tick();
            chk("hold_diff",      {16'd0, diff},      {16'd0, held.d});
            chk("hold_b_out",     {31'd0, b_out},     {31'd0, held.bo});
            chk("hold_out_valid", {31'd0, out_valid}, 32'd1);
            chk("hold_in_ready",  {31'd0, in_ready},  32'd0);
        end
        check_result();
        a         = 16'h00F0;
        b         = 16'h000F;
        b_in      = 1'b0;
        out_ready = 1'b1;
        tick();
        out_ready = 1'b0;
        chk("bp_in_ready_after_consume", {31'd0, in_ready}, 32'd1);
        q.push_back(model(16'h00F0, 16'h000F, 1'b0));
        tick();
        in_valid = 1'b0;
        wait_valid();
        check_result();
        consume();

        run_op(16'h5A5A, 16'h5A5A, 1'b1);

        // Abort on the second RUN cycle
        in_valid = 1'b1;
        a        = 16'h7777;
        b        = 16'h1111;
        b_in     = 1'b0;
        tick();
        in_valid = 1'b0;
        tick();
        rst = 1'b1;
        #1;
        chk("abort_out_valid", {31'd0, out_valid}, 32'd0);
        chk("abort_diff",      {16'd0, diff},      32'd0);
        chk("abort_in_ready",  {31'd0, in_ready},  32'd1);
        chk("abort_b_out",     {31'd0, b_out},     32'd0);
        tick();
        rst = 1'b0;
        for (int i = 0; i < 6; i++) begin
            tick();
            chk("abort_no_valid", {31'd0, out_valid}, 32'd0);
        end
        run_op(16'h0003, 16'h0002, 1'b0);

        for (int i = 0; i < 4; i++) begin
            run_op(16'($urandom), 16'($urandom), 1'($urandom));
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_asserts, n_fail);
        $finish;
    end

endmodule : tb_seq_subtractor
